inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit for the MIPS-lite core. It holds the PC and fetches instructions from instruction memory over a req/ready handshake. Each instruction is presented to decode (`op` to the main controller) through a valid/ready handshake. The next PC is computed from the controller's `Branch`/`Jmp` outputs and the ALU zero flag, sampled at hand-off.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset. Bits [1:0] are forced to 0.
- `CNT_W`, default 32: width of the fetch counter. Used only under `IFETCH_CNT_EN`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: word-aligned fetch address. Equals `pc`.
- `imem_ready` in 1: memory has data on `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: `inst` and `op` are valid for decode.
- `inst_ready` in 1: datapath consumes the instruction this cycle. Controller outputs are valid in the same cycle.
- `inst` out 32: registered instruction.
- `op` out 6: `inst[31:26]`, to the controller.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`, the JAL link value.
- `Branch` in 1: controller branch strobe.
- `Jmp` in 1: controller jump strobe.
- `zero` in 1: ALU equality result for the current instruction.
- `fetch_cnt` out `CNT_W`: accepted-instruction count. Present only with `IFETCH_CNT_EN`.

## Operation
- FSM states:
  - RST: entered while `rst_n`=0.
  - REQ: `imem_req`=1, waiting for `imem_ready`.
  - HOLD: `inst_valid`=1, waiting for `inst_ready`.
- Transitions:
  - RST→REQ on the first edge with `rst_n`=1.
  - REQ→HOLD on `imem_ready`=1. `imem_rdata` is latched into `inst` on that edge.
  - HOLD→REQ on `inst_ready`=1. `pc` is loaded with next-PC on that edge.
  - In all other cases the state holds.
- Next-PC priority, evaluated in HOLD with `inst_ready`=1:
  1. `Jmp`=1: `{pc_plus4[31:28], inst[25:0], 2'b00}`.
  2. `Branch`=1 and `zero`=1: `pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}`.
  3. Otherwise: `pc_plus4`.
- `Jmp` and `Branch` both high: `Jmp` wins.
- `Branch`=1, `zero`=0: not taken, `pc_plus4`.
- All PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Backward branches wrap below 0 the same way.
- `Branch`/`Jmp`/`zero` are ignored outside the HOLD accept cycle.
- `imem_addr` is stable for the whole time `imem_req` is high. `imem_rdata` is ignored when `imem_ready`=0 or the state is not REQ.
- `inst`, `op`, and `pc` are stable for the whole time `inst_valid` is high.
- `rst_n`=0 in any state, including mid-request or mid-hold, returns to RST on that edge:
  - pending request dropped;
  - `pc`=`RESET_PC`;
  - no next-PC update.

## Timing
- Reset values:
  - `imem_req`=0, `inst_valid`=0, `inst`=0, `op`=0;
  - `pc`=`imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4;
  - `fetch_cnt`=0.
- The cycle after reset release: `imem_req`=1.
- `imem_ready` in cycle N → `inst_valid`=1 in cycle N+1. `imem_req`=0 from N+1.
- `inst_ready` in cycle M → new `pc` and `imem_req`=1 in M+1. `inst_valid`=0 from M+1.
- Zero-wait memory and an always-ready datapath give 2 cycles per instruction.
- All outputs are registered or derived combinationally from registers only (`op`, `pc_plus4`, `imem_addr`). There is no input-to-output combinational path.

## Configuration
- `IFETCH_CNT_EN` defined:
  - `fetch_cnt` port exists.
  - It increments by 1 on every HOLD accept and wraps modulo 2^`CNT_W`.
  - Reset clears it to 0.
- `IFETCH_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset sequencing:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release.
  - Required: `imem_req`=0 during reset; `imem_req`=1 with `imem_addr`=32'h3000 one cycle after release.
- Sequential fetch:
  - Stimulus: zero-wait memory, `inst_ready`=1, no branches.
  - Required: `imem_addr` goes 3000, 3004, 3008 every 2 cycles; `op` matches `imem_rdata[31:26]`.
- Taken branch:
  - Stimulus: BEQ at 32'h3010 with imm 16'hFFFC, `Branch`=1, `zero`=1.
  - Required: next `pc`=32'h3004.
  - Stimulus: same instruction with `zero`=0.
  - Required: next `pc`=32'h3014.
- Jump priority:
  - Stimulus: JAL at 32'h3020 with target field 26'h0000C10, `Jmp`=1 and `Branch`=1.
  - Required: next `pc`=32'h0000_3040; `pc_plus4`=32'h3024 during hold.
- Wait states and backpressure:
  - Stimulus: `imem_ready` delayed 3 cycles, `inst_ready` low 2 cycles.
  - Required: `imem_addr` and `inst` stable throughout; exactly one instruction accepted.
  - Stimulus: `rst_n`=0 mid-REQ.
  - Required: `pc`=32'h3000 next cycle.
  - Stimulus: accept 5 instructions with `IFETCH_CNT_EN` defined.
  - Required: `fetch_cnt`=5.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS-lite PC register and instruction fetch FSM (RST -> REQ -> HOLD).
// Define IFETCH_CNT_EN to add the accepted-instruction counter port fetch_cnt.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Jmp,
  input  logic        zero
`ifdef IFETCH_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_HOLD} state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_accept;

  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("inst_fetch: CNT_W must be nonzero");
  end

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_accept = (r_state == S_HOLD) && inst_ready;

  // Jump beats branch; a branch is only taken when the ALU reports equality.
  always_comb begin
    w_next_pc = w_pc4;
    if (Jmp)
      w_next_pc = {w_pc4[31:28], r_inst[25:0], 2'b00};
    else if (Branch && zero)
      w_next_pc = w_pc4 + w_br_off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_pc    <= PC_INIT;
      r_inst  <= '0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            r_inst  <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_RST;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= r_cnt + 1'b1;
  end

  assign fetch_cnt = r_cnt;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign inst_valid = r_valid;
  assign inst       = r_inst;
  assign op         = r_inst[31:26];
  assign pc         = r_pc;
  assign pc_plus4   = w_pc4;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized + directed bench for inst_fetch: transaction-level PC model with an
// instruction scoreboard queue, checked on the falling edge.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n, imem_ready, inst_ready, Branch, Jmp, zero;
  logic [31:0] imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, pc, pc_plus4;
  logic [5:0]  op;
`ifdef IFETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .op(op), .pc(pc), .pc_plus4(pc_plus4),
    .Branch(Branch), .Jmp(Jmp), .zero(zero)
`ifdef IFETCH_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: where the unit should be in the fetch/decode hand-off, what PC
  // it should present, and which fetched words are awaiting decode.
  typedef enum {P_RST, P_FETCH, P_HOLD} phase_t;
  phase_t      m_phase = P_RST;
  logic [31:0] m_pc    = RST_PC;
  int          m_cnt   = 0;
  int          n_acc   = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic br, input logic jp, input logic z);
    logic [31:0]        link;
    logic signed [15:0] imm;
    link = cur + 32'd4;
    imm  = w[15:0];
    if (jp)           return {link[31:28], w[25:0], 2'b00};
    else if (br && z) return link + 32'(int'(imm) * 4);
    else              return link;
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_phase == P_FETCH});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_phase == P_HOLD});
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    if (m_phase == P_RST) begin
      chk("inst_rst", inst, 32'd0);
      chk("op_rst", {26'd0, op}, 32'd0);
    end
    if (m_phase == P_HOLD) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        chk("inst", inst, exp_q[0]);
        chk("op", {26'd0, op}, {26'd0, exp_q[0][31:26]});
      end
    end
`ifdef IFETCH_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'(m_cnt));
`endif
    if (!rst_n) begin
      m_phase = P_RST; m_pc = RST_PC; m_cnt = 0; exp_q.delete();
    end else begin
      case (m_phase)
        P_RST:   m_phase = P_FETCH;
        P_FETCH: if (imem_ready) begin exp_q.push_back(imem_rdata); m_phase = P_HOLD; end
        P_HOLD:  if (inst_ready && exp_q.size() != 0) begin
          w = exp_q.pop_front();
          m_pc = ref_next(m_pc, w, Branch, Jmp, zero);
          m_cnt++; n_acc++;
          m_phase = P_FETCH;
        end
        default: m_phase = P_RST;
      endcase
    end
  end

  task automatic step(input logic rn, input logic mr, input logic [31:0] rd,
                      input logic ir, input logic br, input logic jp, input logic z);
    rst_n = rn; imem_ready = mr; imem_rdata = rd; inst_ready = ir;
    Branch = br; Jmp = jp; zero = z;
    @(posedge clk); #1;
  endtask

  // One zero-wait fetch followed by an immediate accept.
  task automatic fetch_one(input logic [31:0] w, input logic br, input logic jp, input logic z);
    step(1'b1, 1'b1, w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    step(1'b1, 1'b0, $urandom, 1'b1, br, jp, z);
  endtask

  initial begin
    logic [31:0] beq, jal, w;
    int acc0;
    beq = {6'h04, 5'd1, 5'd2, 16'hFFFC};
    jal = {6'h03, 26'h0000C10};
    rst_n = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0;
    Branch = 1'b0; Jmp = 1'b0; zero = 1'b0; imem_rdata = '0;

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("req_after_rel", {31'd0, imem_req}, 32'd1);
    chk("addr_after_rel", imem_addr, 32'h3000);

    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'h3000 + 32'(i * 4));
      fetch_one($urandom, 1'b0, 1'b0, 1'b0);
    end
    chk("beq_addr", imem_addr, 32'h3010);
    fetch_one(beq, 1'b1, 1'b0, 1'b1);
    chk("beq_taken_pc", pc, 32'h3004);
`ifdef IFETCH_CNT_EN
    chk("fetch_cnt_5", fetch_cnt, 32'd5);
`endif
    for (int i = 0; i < 3; i++) fetch_one($urandom, 1'b0, 1'b0, 1'b0);
    fetch_one(beq, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken_pc", pc, 32'h3014);
    for (int i = 0; i < 3; i++) fetch_one($urandom, 1'b0, 1'b0, 1'b0);

    chk("jal_addr", imem_addr, 32'h3020);
    step(1'b1, 1'b1, jal, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jal_pc_plus4", pc_plus4, 32'h3024);
    step(1'b1, 1'b0, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("jal_pc", pc, 32'h3040);

    // Memory wait states then decode backpressure on a single instruction.
    acc0 = n_acc;
    w = $urandom;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("wait_addr", imem_addr, 32'h3040);
    end
    step(1'b1, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), $urandom, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      chk("bp_inst", inst, w);
    end
    step(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("one_accept", 32'(n_acc - acc0), 32'd1);
    chk("bp_next_pc", pc, 32'h3044);

    // Wrap-around: far backward branch, jump to top word, then sequential to 0.
    fetch_one({6'h04, 10'd0, 16'h8000}, 1'b1, 1'b0, 1'b1);
    chk("back_wrap_pc", pc, 32'hFFFE_3048);
    fetch_one({6'h03, 26'h3FF_FFFF}, 1'b0, 1'b1, 1'b0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch_one($urandom, 1'b0, 1'b0, 1'b0);
    chk("wrap_zero_pc", pc, 32'h0000_0000);

    // Reset while a request is outstanding.
    step(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midreq_rst_pc", pc, 32'h3000);
    chk("midreq_rst_req", {31'd0, imem_req}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) != 0, 1'($urandom), $urandom, 1'($urandom),
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3, 1'($urandom));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
